r22_sdf_feedback_stage: RTL and testbench



---
 rtl/r22_sdf_feedback_stage.sv | 109 ++++++++++
 tb/tb_r22_sdf_feedback_stage.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/r22_sdf_feedback_stage.sv
// Radix-2^2 SDF feedback stage: delay line, sample counter, fill tracking and
// registered output around an external combinational butterfly.
module r22_sdf_feedback_stage #(
    parameter int WIDTH   = 16,
    parameter int DELAY   = 8,
    parameter int CONJ_EN = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    input  logic             i_sof,
    input  logic [WIDTH-1:0] i_re,
    input  logic [WIDTH-1:0] i_im,
    output logic [WIDTH-1:0] bf_rX,
    output logic [WIDTH-1:0] bf_iX,
    output logic [WIDTH-1:0] bf_rX2,
    output logic [WIDTH-1:0] bf_iX2,
    output logic             bf_control,
    output logic             bf_conjugate,
    input  logic [WIDTH-1:0] bf_rZ,
    input  logic [WIDTH-1:0] bf_iZ,
    input  logic [WIDTH-1:0] bf_rZ2,
    input  logic [WIDTH-1:0] bf_iZ2,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_re,
    output logic [WIDTH-1:0] o_im
);

    localparam int AW = $clog2(DELAY);
    localparam int CW = AW + 2;
    localparam int FW = AW + 1;
    localparam logic [FW-1:0] FILL_TGT = FW'(DELAY);

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic [CW-1:0]    idx;
    logic [FW-1:0]    fill_q;
    logic [FW-1:0]    fill_d;
    logic             sof_acc;
    logic             run_eff;
    logic [WIDTH-1:0] dl_re_q [DELAY];
    logic [WIDTH-1:0] dl_im_q [DELAY];
    logic             o_valid_q;
    logic [WIDTH-1:0] o_re_q;
    logic [WIDTH-1:0] o_im_q;

    assign sof_acc = i_sof & i_valid;
    assign idx     = sof_acc ? '0 : cnt_q;
    // counter width is exactly log2(4*DELAY), so the +1 wraps for free
    assign cnt_d   = idx + 1'b1;
    assign fill_d  = fill_q + 1'b1;
    // a resync sample starts a new fill, so it never produces output
    assign run_eff = (state_q == ST_RUN) & ~i_sof;

    assign bf_control   = idx[AW];
    assign bf_conjugate = (CONJ_EN != 0) & idx[AW] & idx[AW+1];
    assign bf_rX        = dl_re_q[0];
    assign bf_iX        = dl_im_q[0];
    assign bf_rX2       = i_re;
    assign bf_iX2       = i_im;

    assign o_valid = o_valid_q;
    assign o_re    = o_re_q;
    assign o_im    = o_im_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_FILL;
            cnt_q     <= '0;
            fill_q    <= '0;
            o_valid_q <= 1'b0;
            o_re_q    <= '0;
            o_im_q    <= '0;
            for (int i = 0; i < DELAY; i++) begin
                dl_re_q[i] <= '0;
                dl_im_q[i] <= '0;
            end
        end else if (i_valid) begin
            cnt_q     <= cnt_d;
            o_valid_q <= run_eff;
            o_re_q    <= bf_rZ;
            o_im_q    <= bf_iZ;
            for (int i = 0; i < DELAY - 1; i++) begin
                dl_re_q[i] <= dl_re_q[i+1];
                dl_im_q[i] <= dl_im_q[i+1];
            end
            dl_re_q[DELAY-1] <= bf_rZ2;
            dl_im_q[DELAY-1] <= bf_iZ2;
            if (i_sof) begin
                fill_q  <= FW'(1);
                state_q <= (DELAY == 1) ? ST_RUN : ST_FILL;
            end else if (state_q == ST_FILL) begin
                fill_q <= fill_d;
                if (fill_d == FILL_TGT) begin
                    state_q <= ST_RUN;
                end
            end
        end else begin
            o_valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_r22_sdf_feedback_stage.sv
// Bench for r22_sdf_feedback_stage: three parameterisations share the stimulus,
// a behavioural butterfly closes each loop, and a scoreboard checks the selected one.
module tb_r22_sdf_feedback_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid;
    logic        i_sof;
    logic [15:0] i_re;
    logic [15:0] i_im;

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // radix-2^2 butterfly; conjugate multiplies X2 by -j
    function automatic logic [63:0] bf_f(input logic [15:0] xr, xi, x2r, x2i,
                                         input logic c, input logic j);
        logic [15:0] ar, ai, sr, si, dr, di;
        ar = j ? x2i : x2r;
        ai = j ? (16'd0 - x2r) : x2i;
        sr = xr + ar;
        si = xi + ai;
        dr = xr - ar;
        di = xi - ai;
        if (c) return {sr, si, dr, di};
        else   return {xr, xi, x2r, x2i};
    endfunction

    logic [15:0] a_rX, a_iX, a_rX2, a_iX2, a_rZ, a_iZ, a_rZ2, a_iZ2, a_ore, a_oim;
    logic        a_ctrl, a_conj, a_ov;
    logic [15:0] b_rX, b_iX, b_rX2, b_iX2, b_rZ, b_iZ, b_rZ2, b_iZ2, b_ore, b_oim;
    logic        b_ctrl, b_conj, b_ov;
    logic [15:0] c_rX, c_iX, c_rX2, c_iX2, c_rZ, c_iZ, c_rZ2, c_iZ2, c_ore, c_oim;
    logic        c_ctrl, c_conj, c_ov;

    assign {a_rZ, a_iZ, a_rZ2, a_iZ2} = bf_f(a_rX, a_iX, a_rX2, a_iX2, a_ctrl, a_conj);
    assign {b_rZ, b_iZ, b_rZ2, b_iZ2} = bf_f(b_rX, b_iX, b_rX2, b_iX2, b_ctrl, b_conj);
    assign {c_rZ, c_iZ, c_rZ2, c_iZ2} = bf_f(c_rX, c_iX, c_rX2, c_iX2, c_ctrl, c_conj);

    r22_sdf_feedback_stage #(.WIDTH(16), .DELAY(2), .CONJ_EN(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_sof(i_sof), .i_re(i_re), .i_im(i_im),
        .bf_rX(a_rX), .bf_iX(a_iX), .bf_rX2(a_rX2), .bf_iX2(a_iX2),
        .bf_control(a_ctrl), .bf_conjugate(a_conj),
        .bf_rZ(a_rZ), .bf_iZ(a_iZ), .bf_rZ2(a_rZ2), .bf_iZ2(a_iZ2),
        .o_valid(a_ov), .o_re(a_ore), .o_im(a_oim));

    r22_sdf_feedback_stage #(.WIDTH(16), .DELAY(1), .CONJ_EN(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_sof(i_sof), .i_re(i_re), .i_im(i_im),
        .bf_rX(b_rX), .bf_iX(b_iX), .bf_rX2(b_rX2), .bf_iX2(b_iX2),
        .bf_control(b_ctrl), .bf_conjugate(b_conj),
        .bf_rZ(b_rZ), .bf_iZ(b_iZ), .bf_rZ2(b_rZ2), .bf_iZ2(b_iZ2),
        .o_valid(b_ov), .o_re(b_ore), .o_im(b_oim));

    r22_sdf_feedback_stage #(.WIDTH(16), .DELAY(1), .CONJ_EN(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_sof(i_sof), .i_re(i_re), .i_im(i_im),
        .bf_rX(c_rX), .bf_iX(c_iX), .bf_rX2(c_rX2), .bf_iX2(c_iX2),
        .bf_control(c_ctrl), .bf_conjugate(c_conj),
        .bf_rZ(c_rZ), .bf_iZ(c_iZ), .bf_rZ2(c_rZ2), .bf_iZ2(c_iZ2),
        .o_valid(c_ov), .o_re(c_ore), .o_im(c_oim));

    int          sel = 0;
    logic        s_ov, s_ctrl, s_conj;
    logic [15:0] s_ore, s_oim, s_rx, s_ix;

    always_comb begin
        s_ov = a_ov; s_ore = a_ore; s_oim = a_oim; s_ctrl = a_ctrl; s_conj = a_conj;
        s_rx = a_rX; s_ix = a_iX;
        if (sel == 1) begin
            s_ov = b_ov; s_ore = b_ore; s_oim = b_oim; s_ctrl = b_ctrl; s_conj = b_conj;
            s_rx = b_rX; s_ix = b_iX;
        end else if (sel == 2) begin
            s_ov = c_ov; s_ore = c_ore; s_oim = c_oim; s_ctrl = c_ctrl; s_conj = c_conj;
            s_rx = c_rX; s_ix = c_iX;
        end
    end

    // reference model state
    int          m_d = 2;
    int          m_conj = 0;
    int          m_cnt, m_fill;
    bit          m_run;
    logic [31:0] m_last;
    logic [31:0] m_dl[$];
    logic [31:0] exp_q[$];
    logic [15:0] cap[$];
    logic        last_ctrl, last_conj;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_fill = 0; m_run = 0; m_last = '0;
        m_dl.delete();
        repeat (m_d) m_dl.push_back('0);
        exp_q.delete();
    endtask

    task automatic select_dut(input int s);
        sel    = s;
        m_d    = (s == 0) ? 2 : 1;
        m_conj = (s == 1) ? 1 : 0;
        model_reset();
    endtask

    task automatic cycle(input bit rst, input bit v, input bit sof,
                         input logic [15:0] re, input logic [15:0] im);
        int          idx, lg;
        bit          c, j, exp_v;
        logic [31:0] head;
        logic [63:0] z;
        @(negedge clk);
        rst_n = rst; i_valid = v; i_sof = sof; i_re = re; i_im = im;
        #1;
        last_ctrl = s_ctrl;
        last_conj = s_conj;
        exp_v = 1'b0;
        lg = $clog2(m_d);
        if (!rst) begin
            model_reset();
        end else begin
            check_eq("head", {s_rx, s_ix}, m_dl[0]);
            if (v) begin
                idx = sof ? 0 : m_cnt;
                c = ((idx >> lg) & 1) != 0;
                j = (m_conj != 0) && c && (((idx >> (lg + 1)) & 1) != 0);
                check_eq("control", {31'd0, s_ctrl}, {31'd0, c});
                check_eq("conjugate", {31'd0, s_conj}, {31'd0, j});
                head = m_dl[0];
                z = bf_f(head[31:16], head[15:0], re, im, c, j);
                if (m_run && !sof) begin
                    exp_q.push_back(z[63:32]);
                    exp_v = 1'b1;
                end
                m_last = z[63:32];
                void'(m_dl.pop_front());
                m_dl.push_back(z[31:0]);
                m_cnt = (idx + 1) % (4 * m_d);
                if (sof) begin
                    m_fill = 1; m_run = 0;
                end else if (!m_run) begin
                    m_fill++;
                end
                if (!m_run && m_fill >= m_d) m_run = 1;
            end
        end
        @(posedge clk);
        #1;
        check_eq("o_valid", {31'd0, s_ov}, {31'd0, exp_v});
        if (!rst) begin
            check_eq("rst_out", {s_ore, s_oim}, 32'd0);
        end else if (!v) begin
            check_eq("hold", {s_ore, s_oim}, m_last);
        end
        if (exp_v && s_ov) begin
            check_eq("out", {s_ore, s_oim}, exp_q.pop_front());
            cap.push_back(s_ore);
        end
    endtask

    task automatic check_stream(input string tag);
        logic [15:0] tab [8];
        tab = '{16'd4, 16'd6, 16'hFFFE, 16'hFFFE, 16'd12, 16'd14, 16'hFFFE, 16'hFFFE};
        check_eq({tag, "_count"}, cap.size(), 32'd8);
        for (int k = 0; k < 8 && k < cap.size(); k++)
            check_eq(tag, {16'd0, cap[k]}, {16'd0, tab[k]});
    endtask

    initial begin
        logic conj_hist[4];
        rst_n = 1'b0; i_valid = 1'b0; i_sof = 1'b0; i_re = '0; i_im = '0;

        // reset with random activity
        select_dut(0);
        for (int k = 0; k < 5; k++)
            cycle(0, 1'($urandom_range(1)), 1'($urandom_range(1)), 16'($urandom), 16'($urandom));
        check_eq("rst_head", {s_rx, s_ix}, 32'd0);

        // continuous streaming, DELAY=2
        cap.delete();
        cycle(1, 1, 1, 16'd1, 16'd0);
        for (int k = 2; k <= 10; k++) cycle(1, 1, 0, 16'(k), 16'd0);
        check_stream("stream");

        // same stimulus with gaps
        cycle(0, 0, 0, 16'd0, 16'd0);
        cap.delete();
        for (int k = 1; k <= 10; k++) begin
            cycle(1, 1, (k == 1), 16'(k), 16'd0);
            cycle(1, 0, 0, 16'($urandom), 16'($urandom));
        end
        check_stream("gaps");

        // resync mid-RUN
        cycle(1, 1, 1, 16'd100, 16'd7);
        check_eq("resync_ctrl", {31'd0, last_ctrl}, 32'd0);
        for (int k = 0; k < 6; k++) cycle(1, 1, 0, 16'(20 + k), 16'(3 * k));

        // reset mid-frame
        cycle(0, 1, 0, 16'd5, 16'd5);
        for (int k = 0; k < 4; k++) cycle(1, 1, 0, 16'(k + 1), 16'd9);

        // conjugate, DELAY=1 BF-II
        select_dut(1);
        cycle(0, 0, 0, 16'd0, 16'd0);
        for (int k = 0; k < 4; k++) begin
            cycle(1, 1, (k == 0), 16'(k + 1), 16'd0);
            conj_hist[k] = last_conj;
        end
        for (int k = 0; k < 4; k++)
            check_eq("conj_hist", {31'd0, conj_hist[k]}, {31'd0, (k == 3)});
        check_eq("conj_out", {s_ore, s_oim}, {16'd3, 16'hFFFC});
        check_eq("conj_dl", {s_rx, s_ix}, {16'd3, 16'd4});

        // modular wrap, DELAY=1 BF-I
        select_dut(2);
        cycle(0, 0, 0, 16'd0, 16'd0);
        cycle(1, 1, 1, 16'h7FFF, 16'd0);
        cycle(1, 1, 0, 16'h0001, 16'd0);
        check_eq("wrap", {s_ore, s_oim}, {16'h8000, 16'd0});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
